// File: rtl/lisp.sv
// Shared Lisp-core definitions: cell type tags, fetch FSM states and tag decode helpers.
package lisp;

  localparam int TAG_WIDTH = 16;

  localparam logic [TAG_WIDTH-1:0] TYPE_NIL    = 16'h0000;
  localparam logic [TAG_WIDTH-1:0] TYPE_NUMBER = 16'h0001;
  localparam logic [TAG_WIDTH-1:0] TYPE_CONS   = 16'h0002;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TAG_REQ   = 3'd1,
    TAG_WAIT  = 3'd2,
    WORD_REQ  = 3'd3,
    WORD_WAIT = 3'd4,
    RESP      = 3'd5
  } fetch_state_t;

  // Number of payload words that follow a tag; unknown tags carry none.
  function automatic logic [1:0] payload_words(input logic [TAG_WIDTH-1:0] tag);
    logic [1:0] words;
    case (tag)
      TYPE_NIL:    words = 2'd0;
      TYPE_NUMBER: words = 2'd1;
      TYPE_CONS:   words = 2'd2;
      default:     words = 2'd0;
    endcase
    return words;
  endfunction

  function automatic logic tag_known(input logic [TAG_WIDTH-1:0] tag);
    logic known;
    case (tag)
      TYPE_NIL:    known = 1'b1;
      TYPE_NUMBER: known = 1'b1;
      TYPE_CONS:   known = 1'b1;
      default:     known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/cell_fetch_cache.sv
// Single-entry last-object cache for cell_fetcher (built only with CELL_FETCH_CACHE_EN).
module cell_fetch_cache
  import lisp::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  invalidate,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] hit_tag,
  output logic [DATA_WIDTH-1:0] hit_word0,
  output logic [DATA_WIDTH-1:0] hit_word1,
  input  logic                  fill_en,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [DATA_WIDTH-1:0] fill_tag,
  input  logic [DATA_WIDTH-1:0] fill_word0,
  input  logic [DATA_WIDTH-1:0] fill_word1
);

  logic                  valid_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] tag_r;
  logic [DATA_WIDTH-1:0] word0_r;
  logic [DATA_WIDTH-1:0] word1_r;

  // A same-cycle invalidate forces a miss so stale data is never returned.
  assign hit       = valid_r && (addr_r == lookup_addr) && !invalidate;
  assign hit_tag   = tag_r;
  assign hit_word0 = word0_r;
  assign hit_word1 = word1_r;

  // Entry storage: invalidate takes priority over a coincident fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      addr_r  <= '0;
      tag_r   <= '0;
      word0_r <= '0;
      word1_r <= '0;
    end else if (invalidate) begin
      valid_r <= 1'b0;
    end else if (fill_en) begin
      valid_r <= 1'b1;
      addr_r  <= fill_addr;
      tag_r   <= fill_tag;
      word0_r <= fill_word0;
      word1_r <= fill_word1;
    end
  end

endmodule

// File: rtl/cell_fetcher.sv
// Tagged-cell fetch unit: reads tag plus payload words and returns the decoded object in one beat.
// Optional single-entry object cache enabled by defining CELL_FETCH_CACHE_EN.
module cell_fetcher
  import lisp::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_tag,
  output logic [DATA_WIDTH-1:0] rsp_word0,
  output logic [DATA_WIDTH-1:0] rsp_word1,
  output logic                  rsp_error,
  input  logic                  invalidate
);

  localparam logic [2:0] LAT_RELOAD = 3'(MEM_LATENCY - 1);

  fetch_state_t          state_r, state_s;
  logic [ADDR_WIDTH-1:0] base_r, base_s;
  logic [2:0]            cnt_r, cnt_s;
  logic [1:0]            nwords_r, nwords_s;
  logic [1:0]            widx_r, widx_s;
  logic [DATA_WIDTH-1:0] tag_r, tag_s;
  logic [DATA_WIDTH-1:0] word0_r, word0_s;
  logic [DATA_WIDTH-1:0] word1_r, word1_s;
  logic                  err_r, err_s;

  logic                  req_ready_r;
  logic                  mem_rd_en_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_tag_r;
  logic [DATA_WIDTH-1:0] rsp_word0_r;
  logic [DATA_WIDTH-1:0] rsp_word1_r;
  logic                  rsp_error_r;

  logic                  cache_hit_s;
  logic [DATA_WIDTH-1:0] cache_tag_s;
  logic [DATA_WIDTH-1:0] cache_word0_s;
  logic [DATA_WIDTH-1:0] cache_word1_s;

  logic                  tag_hi_zero_s;
  logic                  tag_ok_s;
  logic [1:0]            tag_words_s;

  // A tag is only recognised when any bits above the tag field are clear.
  assign tag_hi_zero_s = ((mem_rdata >> TAG_WIDTH) == '0);
  assign tag_ok_s      = tag_hi_zero_s && tag_known(TAG_WIDTH'(mem_rdata));
  assign tag_words_s   = tag_ok_s ? payload_words(TAG_WIDTH'(mem_rdata)) : 2'd0;

`ifdef CELL_FETCH_CACHE_EN
  logic fill_en_s;

  // Fill only on memory-sourced, non-error completions (a hit enters RESP straight from IDLE).
  assign fill_en_s = (state_s == RESP) && (state_r != IDLE) && !err_s;

  cell_fetch_cache #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cache (
    .clk         (clk),
    .rst         (rst),
    .invalidate  (invalidate),
    .lookup_addr (req_addr),
    .hit         (cache_hit_s),
    .hit_tag     (cache_tag_s),
    .hit_word0   (cache_word0_s),
    .hit_word1   (cache_word1_s),
    .fill_en     (fill_en_s),
    .fill_addr   (base_s),
    .fill_tag    (tag_s),
    .fill_word0  (word0_s),
    .fill_word1  (word1_s)
  );
`else
  logic unused_s;

  assign unused_s      = invalidate;
  assign cache_hit_s   = 1'b0;
  assign cache_tag_s   = '0;
  assign cache_word0_s = '0;
  assign cache_word1_s = '0;
`endif

  // Next-state and working-register logic of the fetch sequencer.
  always_comb begin
    state_s  = state_r;
    base_s   = base_r;
    cnt_s    = cnt_r;
    nwords_s = nwords_r;
    widx_s   = widx_r;
    tag_s    = tag_r;
    word0_s  = word0_r;
    word1_s  = word1_r;
    err_s    = err_r;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready_r) begin
          base_s   = req_addr;
          nwords_s = 2'd0;
          widx_s   = 2'd1;
          err_s    = 1'b0;
          if (cache_hit_s) begin
            tag_s   = cache_tag_s;
            word0_s = cache_word0_s;
            word1_s = cache_word1_s;
            state_s = RESP;
          end else begin
            tag_s   = '0;
            word0_s = '0;
            word1_s = '0;
            state_s = TAG_REQ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      TAG_REQ: begin
        cnt_s   = LAT_RELOAD;
        state_s = TAG_WAIT;
      end
      TAG_WAIT: begin
        if (cnt_r == 3'd0) begin
          tag_s    = mem_rdata;
          nwords_s = tag_words_s;
          err_s    = !tag_ok_s;
          if (tag_words_s == 2'd0) begin
            state_s = RESP;
          end else begin
            state_s = WORD_REQ;
          end
        end else begin
          cnt_s = cnt_r - 3'd1;
        end
      end
      WORD_REQ: begin
        cnt_s   = LAT_RELOAD;
        state_s = WORD_WAIT;
      end
      WORD_WAIT: begin
        if (cnt_r == 3'd0) begin
          if (widx_r == 2'd1) begin
            word0_s = mem_rdata;
          end else begin
            word1_s = mem_rdata;
          end
          if (widx_r >= nwords_r) begin
            state_s = RESP;
          end else begin
            widx_s  = widx_r + 2'd1;
            state_s = WORD_REQ;
          end
        end else begin
          cnt_s = cnt_r - 3'd1;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Sequencer state and working registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      base_r   <= '0;
      cnt_r    <= 3'd0;
      nwords_r <= 2'd0;
      widx_r   <= 2'd1;
      tag_r    <= '0;
      word0_r  <= '0;
      word1_r  <= '0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      base_r   <= base_s;
      cnt_r    <= cnt_s;
      nwords_r <= nwords_s;
      widx_r   <= widx_s;
      tag_r    <= tag_s;
      word0_r  <= word0_s;
      word1_r  <= word1_s;
      err_r    <= err_s;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready_r <= 1'b1;
      mem_rd_en_r <= 1'b0;
      mem_addr_r  <= '0;
      rsp_valid_r <= 1'b0;
      rsp_tag_r   <= '0;
      rsp_word0_r <= '0;
      rsp_word1_r <= '0;
      rsp_error_r <= 1'b0;
    end else begin
      req_ready_r <= (state_s == IDLE);
      mem_rd_en_r <= (state_s == TAG_REQ) || (state_s == WORD_REQ);
      if (state_s == TAG_REQ) begin
        mem_addr_r <= base_s;
      end else if (state_s == WORD_REQ) begin
        mem_addr_r <= base_s + ADDR_WIDTH'(widx_s);
      end
      rsp_valid_r <= (state_s == RESP);
      if (state_s == RESP) begin
        rsp_tag_r   <= tag_s;
        rsp_word0_r <= word0_s;
        rsp_word1_r <= word1_s;
        rsp_error_r <= err_s;
      end
    end
  end

  assign req_ready = req_ready_r;
  assign mem_rd_en = mem_rd_en_r;
  assign mem_addr  = mem_addr_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_tag   = rsp_tag_r;
  assign rsp_word0 = rsp_word0_r;
  assign rsp_word1 = rsp_word1_r;
  assign rsp_error = rsp_error_r;

endmodule

// File: tb/tb_cell_fetcher.sv
// Directed bench for cell_fetcher: two instances (MEM_LATENCY 1 and 3) share stimulus and memory image.
// Cache scenario runs only when CELL_FETCH_CACHE_EN is defined.
module tb_cell_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        invalidate;
  logic [15:0] req_addr;

  logic        ready [2];
  logic        rd_en [2];
  logic        rsp_v [2];
  logic        rerr  [2];
  logic [15:0] maddr [2];
  logic [15:0] rdata [2];
  logic [15:0] rtag  [2];
  logic [15:0] rw0   [2];
  logic [15:0] rw1   [2];

  logic [15:0] mem [65536];
  logic [15:0] pipe1;
  logic [15:0] pipe3 [3];

  int checks = 0;
  int errors = 0;

  int          nrd [2];
  int          nrsp [2];
  int          rsp_cyc [2];
  int          rsp_cyc2 [2];
  logic        ready_after [2];
  logic [15:0] rda0 [2];
  logic [15:0] rda1 [2];
  logic [15:0] o_tag [2];
  logic [15:0] o_w0 [2];
  logic [15:0] o_w1 [2];
  logic        o_err [2];

  always #5 clk = ~clk;

  cell_fetcher #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready[0]), .req_addr(req_addr),
    .mem_rd_en(rd_en[0]), .mem_addr(maddr[0]), .mem_rdata(rdata[0]), .rsp_valid(rsp_v[0]),
    .rsp_tag(rtag[0]), .rsp_word0(rw0[0]), .rsp_word1(rw1[0]), .rsp_error(rerr[0]),
    .invalidate(invalidate)
  );

  cell_fetcher #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready[1]), .req_addr(req_addr),
    .mem_rd_en(rd_en[1]), .mem_addr(maddr[1]), .mem_rdata(rdata[1]), .rsp_valid(rsp_v[1]),
    .rsp_tag(rtag[1]), .rsp_word0(rw0[1]), .rsp_word1(rw1[1]), .rsp_error(rerr[1]),
    .invalidate(invalidate)
  );

  // Memory models: data valid exactly L cycles after the strobe, poison otherwise.
  always @(posedge clk) begin
    pipe1    <= rd_en[0] ? mem[maddr[0]] : 16'hDEAD;
    pipe3[0] <= rd_en[1] ? mem[maddr[1]] : 16'hDEAD;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign rdata[0] = pipe1;
  assign rdata[1] = pipe3[2];

  // Issue one request at cycle 0 and record both instances' activity for cycles 1..budget.
  task automatic do_fetch(input logic [15:0] addr, input logic hold, input logic inv, input int budget);
    for (int d = 0; d < 2; d++) begin
      nrd[d] = 0; nrsp[d] = 0; rsp_cyc[d] = -1; rsp_cyc2[d] = -1; ready_after[d] = 1'b0;
      rda0[d] = 16'hBEEF; rda1[d] = 16'hBEEF;
      o_tag[d] = 16'hBEEF; o_w0[d] = 16'hBEEF; o_w1[d] = 16'hBEEF; o_err[d] = 1'bx;
    end
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; invalidate = inv;
    @(posedge clk);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      invalidate = 1'b0;
      if (!hold) req_valid = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (rd_en[d]) begin
          if (nrd[d] == 0) rda0[d] = maddr[d];
          else if (nrd[d] == 1) rda1[d] = maddr[d];
          nrd[d]++;
        end
        if (rsp_v[d]) begin
          if (nrsp[d] == 0) begin
            rsp_cyc[d] = c; o_tag[d] = rtag[d]; o_w0[d] = rw0[d]; o_w1[d] = rw1[d]; o_err[d] = rerr[d];
          end else if (nrsp[d] == 1) begin
            rsp_cyc2[d] = c;
          end
          nrsp[d]++;
        end
        if (rsp_cyc[d] >= 0 && c == rsp_cyc[d] + 1) ready_after[d] = ready[d];
      end
    end
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; invalidate = 1'b0; req_addr = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rsp_v[d], rd_en[d], rerr[d], rtag[d], rw0[d], rw1[d], maddr[d], ready[d]} !== {3'b000, 64'h0, 1'b1}) begin
        errors++;
        $display("FAIL reset_state dut%0d got v=%b rd=%b err=%b tag=%h w0=%h w1=%h addr=%h rdy=%b exp all 0, rdy=1",
                 d, rsp_v[d], rd_en[d], rerr[d], rtag[d], rw0[d], rw1[d], maddr[d], ready[d]);
      end
    end
  endtask

  task automatic test_number();
    do_fetch(16'h0010, 1'b0, 1'b0, 16);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rsp_cyc[d] !== (d == 0 ? 5 : 9)) begin
        errors++; $display("FAIL number_rsp_cycle dut%0d got %0d exp %0d", d, rsp_cyc[d], (d == 0 ? 5 : 9));
      end
      checks++;
      if ({o_tag[d], o_w0[d], o_w1[d], o_err[d]} !== {16'h0001, 16'h002A, 16'h0000, 1'b0}) begin
        errors++; $display("FAIL number_fields dut%0d got %h/%h/%h/%b exp 0001/002a/0000/0", d, o_tag[d], o_w0[d], o_w1[d], o_err[d]);
      end
      checks++;
      if ({nrd[d], rda0[d], rda1[d], nrsp[d]} !== {32'd2, 16'h0010, 16'h0011, 32'd1}) begin
        errors++; $display("FAIL number_reads dut%0d got n=%0d a0=%h a1=%h rsp=%0d exp n=2 a0=0010 a1=0011 rsp=1", d, nrd[d], rda0[d], rda1[d], nrsp[d]);
      end
    end
  endtask

  task automatic test_cons();
    do_fetch(16'h0020, 1'b0, 1'b0, 16);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rsp_cyc[d] !== (d == 0 ? 7 : 13)) begin
        errors++; $display("FAIL cons_rsp_cycle dut%0d got %0d exp %0d", d, rsp_cyc[d], (d == 0 ? 7 : 13));
      end
      checks++;
      if ({o_tag[d], o_w0[d], o_w1[d], o_err[d]} !== {16'h0002, 16'h0030, 16'h0040, 1'b0}) begin
        errors++; $display("FAIL cons_fields dut%0d got %h/%h/%h/%b exp 0002/0030/0040/0", d, o_tag[d], o_w0[d], o_w1[d], o_err[d]);
      end
      checks++;
      if ({nrd[d], rda1[d]} !== {32'd3, 16'h0021}) begin
        errors++; $display("FAIL cons_reads dut%0d got n=%0d a1=%h exp n=3 a1=0021", d, nrd[d], rda1[d]);
      end
    end
  endtask

  task automatic test_error_nil();
    do_fetch(16'h0005, 1'b0, 1'b0, 16);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rsp_cyc[d] !== (d == 0 ? 3 : 5)) begin
        errors++; $display("FAIL error_rsp_cycle dut%0d got %0d exp %0d", d, rsp_cyc[d], (d == 0 ? 3 : 5));
      end
      checks++;
      if ({o_tag[d], o_w0[d], o_w1[d], o_err[d], nrd[d]} !== {16'h00FF, 16'h0000, 16'h0000, 1'b1, 32'd1}) begin
        errors++; $display("FAIL error_fields dut%0d got %h/%h/%h/%b reads=%0d exp 00ff/0000/0000/1 reads=1", d, o_tag[d], o_w0[d], o_w1[d], o_err[d], nrd[d]);
      end
    end
    do_fetch(16'h0006, 1'b0, 1'b0, 16);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rsp_cyc[d] !== (d == 0 ? 3 : 5)) begin
        errors++; $display("FAIL nil_rsp_cycle dut%0d got %0d exp %0d", d, rsp_cyc[d], (d == 0 ? 3 : 5));
      end
      checks++;
      if ({o_tag[d], o_w0[d], o_w1[d], o_err[d]} !== {16'h0000, 16'h0000, 16'h0000, 1'b0}) begin
        errors++; $display("FAIL nil_fields dut%0d got %h/%h/%h/%b exp 0000/0000/0000/0", d, o_tag[d], o_w0[d], o_w1[d], o_err[d]);
      end
    end
  endtask

  task automatic test_wrap();
    do_fetch(16'hFFFF, 1'b0, 1'b0, 16);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rda0[d], rda1[d], o_w0[d]} !== {16'hFFFF, 16'h0000, 16'h1234}) begin
        errors++; $display("FAIL wrap_addr dut%0d got a0=%h a1=%h w0=%h exp ffff/0000/1234", d, rda0[d], rda1[d], o_w0[d]);
      end
      checks++;
      if (rsp_cyc[d] !== (d == 0 ? 5 : 9)) begin
        errors++; $display("FAIL wrap_rsp_cycle dut%0d got %0d exp %0d", d, rsp_cyc[d], (d == 0 ? 5 : 9));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_fetch(16'h0005, 1'b1, 1'b0, 14);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rsp_cyc[d], rsp_cyc2[d]} !== {(d == 0 ? 32'd3 : 32'd5), (d == 0 ? 32'd7 : 32'd11)}) begin
        errors++; $display("FAIL b2b_cycles dut%0d got %0d,%0d exp %0d,%0d", d, rsp_cyc[d], rsp_cyc2[d], (d == 0 ? 3 : 5), (d == 0 ? 7 : 11));
      end
      checks++;
      if ({ready_after[d], o_err[d]} !== 2'b11) begin
        errors++; $display("FAIL b2b_ready dut%0d got ready_after=%b err=%b exp 1/1", d, ready_after[d], o_err[d]);
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    int          n_rsp [2];
    int          first_rsp [2];
    int          busy_ready [2];
    int          post_rd [2];
    logic [15:0] post_a0 [2];
    logic [15:0] f_tag [2];
    logic [15:0] f_w0 [2];
    for (int d = 0; d < 2; d++) begin
      n_rsp[d] = 0; first_rsp[d] = -1; busy_ready[d] = 0; post_rd[d] = 0;
      post_a0[d] = 16'hBEEF; f_tag[d] = 16'hBEEF; f_w0[d] = 16'hBEEF;
    end
    @(negedge clk);
    req_valid = 1'b1; req_addr = 16'h0020;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rsp_v[d]) begin
          if (n_rsp[d] == 0) begin first_rsp[d] = c; f_tag[d] = rtag[d]; f_w0[d] = rw0[d]; end
          n_rsp[d]++;
        end
        if (c >= 8 && c <= (d == 0 ? 12 : 16) && ready[d]) busy_ready[d]++;
        if (c >= 8 && rd_en[d]) begin
          if (post_rd[d] == 0) post_a0[d] = maddr[d];
          post_rd[d]++;
        end
        if (c == 7) begin
          checks++;
          if ({rsp_v[d], rd_en[d], rerr[d], rtag[d], rw0[d], rw1[d], maddr[d], ready[d]} !== {3'b000, 64'h0, 1'b1}) begin
            errors++;
            $display("FAIL midreset_state dut%0d got v=%b rd=%b err=%b tag=%h w0=%h w1=%h addr=%h rdy=%b exp all 0, rdy=1",
                     d, rsp_v[d], rd_en[d], rerr[d], rtag[d], rw0[d], rw1[d], maddr[d], ready[d]);
          end
        end
      end
      if (c == 6) begin rst = 1'b1; req_addr = 16'h0010; end
      if (c == 7) rst = 1'b0;
      if (c == 12) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({n_rsp[d], first_rsp[d]} !== {32'd1, (d == 0 ? 32'd12 : 32'd16)}) begin
        errors++; $display("FAIL midreset_rsp dut%0d got count=%0d cycle=%0d exp count=1 cycle=%0d", d, n_rsp[d], first_rsp[d], (d == 0 ? 12 : 16));
      end
      checks++;
      if ({f_tag[d], f_w0[d], busy_ready[d], post_rd[d], post_a0[d]} !== {16'h0001, 16'h002A, 32'd0, 32'd2, 16'h0010}) begin
        errors++; $display("FAIL midreset_refetch dut%0d got tag=%h w0=%h busy_ready=%0d reads=%0d a0=%h exp 0001/002a/0/2/0010",
                           d, f_tag[d], f_w0[d], busy_ready[d], post_rd[d], post_a0[d]);
      end
    end
  endtask

`ifdef CELL_FETCH_CACHE_EN
  task automatic test_cache();
    do_fetch(16'h0010, 1'b0, 1'b0, 16);
    do_fetch(16'h0010, 1'b0, 1'b0, 16);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rsp_cyc[d], nrd[d], o_tag[d], o_w0[d]} !== {32'd1, 32'd0, 16'h0001, 16'h002A}) begin
        errors++; $display("FAIL cache_hit dut%0d got cycle=%0d reads=%0d tag=%h w0=%h exp 1/0/0001/002a", d, rsp_cyc[d], nrd[d], o_tag[d], o_w0[d]);
      end
    end
    @(negedge clk); invalidate = 1'b1;
    @(negedge clk); invalidate = 1'b0;
    do_fetch(16'h0010, 1'b0, 1'b0, 16);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rsp_cyc[d], nrd[d]} !== {(d == 0 ? 32'd5 : 32'd9), 32'd2}) begin
        errors++; $display("FAIL cache_invalidate dut%0d got cycle=%0d reads=%0d exp %0d/2", d, rsp_cyc[d], nrd[d], (d == 0 ? 5 : 9));
      end
    end
    do_fetch(16'h0010, 1'b0, 1'b1, 16);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rsp_cyc[d], nrd[d]} !== {(d == 0 ? 32'd5 : 32'd9), 32'd2}) begin
        errors++; $display("FAIL cache_inv_accept dut%0d got cycle=%0d reads=%0d exp %0d/2", d, rsp_cyc[d], nrd[d], (d == 0 ? 5 : 9));
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = 1'b0; invalidate = 1'b0; req_addr = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0010] = 16'h0001; mem[16'h0011] = 16'h002A;
    mem[16'h0020] = 16'h0002; mem[16'h0021] = 16'h0030; mem[16'h0022] = 16'h0040;
    mem[16'h0005] = 16'h00FF; mem[16'h0006] = 16'h0000;
    mem[16'hFFFF] = 16'h0001; mem[16'h0000] = 16'h1234;
    test_reset();
    test_number();
    test_cons();
    test_error_nil();
    test_wrap();
    test_back_to_back();
    test_reset_mid_fetch();
`ifdef CELL_FETCH_CACHE_EN
    test_cache();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
